// File: rtl/colparity_pkg.sv
// Shared types for the column-parity control unit: state encoding, control
// word layout and the Moore decode from state to control word.
package colparity_pkg;

    localparam int SLICES_DEF = 64;
    localparam int LANES_DEF  = 25;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        LOAD_CURR,
        PAR1,
        LOAD_PRE,
        PAR2,
        WRITE,
        READ,
        DONE
    } state_t;

    typedef struct packed {
        logic ready;
        logic busy;
        logic done;
        logic ld_x;
        logic curr_in_sel;
        logic pre_in_sel;
        logic ld_m;
        logic parity_en;
        logic mem_write;
        logic mem_read;
    } ctrl_t;

    function automatic ctrl_t decode(state_t s);
        ctrl_t c;
        c             = '0;
        c.ready       = (s == IDLE);
        c.busy        = (s != IDLE) && (s != DONE);
        c.done        = (s == DONE);
        c.ld_x        = (s == LOAD_CURR) || (s == LOAD_PRE);
        c.curr_in_sel = (s == LOAD_CURR);
        c.pre_in_sel  = (s == LOAD_PRE);
        c.ld_m        = (s == LOAD_PRE);
        c.parity_en   = (s == PAR1) || (s == PAR2);
        c.mem_write   = (s == WRITE);
        c.mem_read    = (s == READ);
        return c;
    endfunction

endpackage

// File: rtl/colparity_ctrl_gen_mod_counter.sv
// Modulo-MOD up counter with synchronous clear; co flags the terminal count
// and the counter wraps to zero when incremented there.
module mod_counter #(
    parameter  int MOD = 4,
    localparam int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         co
);

    assign co = (cnt == W'(MOD - 1));

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc)
            cnt <= co ? '0 : cnt + W'(1);
    end

endmodule

// File: rtl/colparity_ctrl_gen.sv
// Column-parity sequencer: walks SLICES slices, LANES lanes per parity pass,
// with optional second pass over the previous slice and a stallable memory handshake.
module colparity_ctrl_gen
    import colparity_pkg::*;
#(
    parameter  int SLICES  = SLICES_DEF,
    parameter  int LANES   = LANES_DEF,
    localparam int SLICE_W = $clog2(SLICES),
    localparam int LANE_W  = $clog2(LANES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    input  logic               abort,
    input  logic               mem_ack,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic               ld_x,
    output logic               curr_in_sel,
    output logic               pre_in_sel,
    output logic               ld_m,
    output logic               parity_en,
    output logic               mem_write,
    output logic               mem_read,
    output logic [SLICE_W-1:0] slice_idx,
    output logic [SLICE_W-1:0] prev_slice_idx,
    output logic [LANE_W-1:0]  lane_idx
);

    state_t state, state_nx;
    ctrl_t  ctl_q;
    logic   mode_q;
    logic   kill;
    logic   slice_clr, slice_inc, slice_co;
    logic   lane_clr, lane_inc, lane_co;

    // abort is meaningless in IDLE so that a coincident start still wins
    assign kill = abort && (state != IDLE);

    always_comb begin
        state_nx = state;
        if (kill) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:      if (start) state_nx = INIT;
                INIT:      state_nx = LOAD_CURR;
                LOAD_CURR: state_nx = PAR1;
                PAR1:      if (lane_co) state_nx = mode_q ? WRITE : LOAD_PRE;
                LOAD_PRE:  state_nx = PAR2;
                PAR2:      if (lane_co) state_nx = WRITE;
                WRITE:     if (mem_ack) state_nx = READ;
                READ:      if (mem_ack) state_nx = slice_co ? DONE : LOAD_CURR;
                DONE:      state_nx = IDLE;
                default:   state_nx = IDLE;
            endcase
        end
    end

    assign slice_clr = kill || (state == INIT);
    assign slice_inc = (state == READ) && mem_ack && !slice_co;
    assign lane_clr  = kill || (state == LOAD_CURR) || (state == LOAD_PRE);
    assign lane_inc  = (state == PAR1) || (state == PAR2);

    // Control word is decoded from the next state so outputs stay Moore but registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mode_q <= 1'b0;
            ctl_q  <= decode(IDLE);
        end else begin
            state <= state_nx;
            ctl_q <= decode(state_nx);
            if (state == IDLE && start)
                mode_q <= mode;
        end
    end

    mod_counter #(.MOD(SLICES)) u_slice_cnt (
        .clk (clk),
        .rst (rst),
        .clr (slice_clr),
        .inc (slice_inc),
        .cnt (slice_idx),
        .co  (slice_co)
    );

    mod_counter #(.MOD(LANES)) u_lane_cnt (
        .clk (clk),
        .rst (rst),
        .clr (lane_clr),
        .inc (lane_inc),
        .cnt (lane_idx),
        .co  (lane_co)
    );

    assign prev_slice_idx = (slice_idx == '0) ? SLICE_W'(SLICES - 1)
                                              : slice_idx - SLICE_W'(1);

    assign ready       = ctl_q.ready;
    assign busy        = ctl_q.busy;
    assign done        = ctl_q.done;
    assign ld_x        = ctl_q.ld_x;
    assign curr_in_sel = ctl_q.curr_in_sel;
    assign pre_in_sel  = ctl_q.pre_in_sel;
    assign ld_m        = ctl_q.ld_m;
    assign parity_en   = ctl_q.parity_en;
    assign mem_write   = ctl_q.mem_write;
    assign mem_read    = ctl_q.mem_read;

    a_lane_range: assert property (@(posedge clk) disable iff (rst)
        lane_idx <= LANE_W'(LANES - 1));
    a_slice_range: assert property (@(posedge clk) disable iff (rst)
        slice_idx <= SLICE_W'(SLICES - 1));

endmodule

// File: tb/tb_colparity_ctrl_gen.sv
// Bench for colparity_ctrl_gen: an expected per-cycle trace is built from the
// run rules (slices, passes, stalls) and compared against the DUT cycle by cycle.
module tb_colparity_ctrl_gen;

    localparam int S  = 4;
    localparam int L  = 3;
    localparam int SW = $clog2(S);
    localparam int LW = $clog2(L);

    localparam int K_INIT = 0, K_LC = 1, K_P1 = 2, K_LP = 3, K_P2 = 4, K_WR = 5, K_RD = 6, K_DN = 7;
    // control bits: ready busy done ld_x curr pre ld_m par mw mr
    localparam logic [9:0] C_IDLE = 10'b1000000000, C_INIT = 10'b0100000000,
                           C_LC = 10'b0101100000, C_LP = 10'b0101011000,
                           C_PAR = 10'b0100000100, C_WR = 10'b0100000010,
                           C_RD = 10'b0100000001, C_DN = 10'b0010000000;

    logic clk = 1'b0, rst = 1'b1;
    logic start = 1'b0, mode = 1'b0, abort = 1'b0, mem_ack = 1'b0;
    logic ready, busy, done, ld_x, curr_in_sel, pre_in_sel, ld_m, parity_en, mem_write, mem_read;
    logic [SW-1:0] slice_idx, prev_slice_idx;
    logic [LW-1:0] lane_idx;
    logic [9:0] obs;

    int nvec = 0, miss = 0, n_stall = 0;

    typedef struct {
        int            kind;
        int            sl;
        logic [9:0]    ctl;
        logic [SW-1:0] slice, prev;
        logic [LW-1:0] lane;
        bit            chk_slice, chk_lane;
        logic          ack;
    } rec_t;
    rec_t tq[$];

    colparity_ctrl_gen #(.SLICES(S), .LANES(L)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort), .mem_ack(mem_ack),
        .ready(ready), .busy(busy), .done(done), .ld_x(ld_x), .curr_in_sel(curr_in_sel),
        .pre_in_sel(pre_in_sel), .ld_m(ld_m), .parity_en(parity_en), .mem_write(mem_write),
        .mem_read(mem_read), .slice_idx(slice_idx), .prev_slice_idx(prev_slice_idx),
        .lane_idx(lane_idx)
    );

    assign obs = {ready, busy, done, ld_x, curr_in_sel, pre_in_sel, ld_m, parity_en, mem_write, mem_read};

    always #5 clk = ~clk;

    function automatic void push(int k, int s, logic [9:0] c, bit cs, int ln, bit cl, logic a);
        rec_t r;
        r.kind = k; r.sl = s; r.ctl = c;
        r.slice = SW'(s); r.prev = SW'((s + S - 1) % S);
        r.lane = LW'(ln); r.chk_slice = cs; r.chk_lane = cl; r.ack = a;
        tq.push_back(r);
    endfunction

    // smode: 0 = no stalls, 1 = 3 stall cycles per access, 2 = random 0..3
    task automatic build(input bit m, input int smode);
        int k;
        tq.delete();
        n_stall = 0;
        push(K_INIT, 0, C_INIT, 0, 0, 0, 1'($urandom));
        for (int s = 0; s < S; s++) begin
            push(K_LC, s, C_LC, 1, 0, 0, 1'($urandom));
            for (int i = 0; i < L; i++) push(K_P1, s, C_PAR, 1, i, 1, 1'($urandom));
            if (!m) begin
                push(K_LP, s, C_LP, 1, 0, 0, 1'($urandom));
                for (int i = 0; i < L; i++) push(K_P2, s, C_PAR, 1, i, 1, 1'($urandom));
            end
            for (int a = 0; a < 2; a++) begin
                k = (smode == 0) ? 0 : (smode == 1) ? 3 : int'($urandom_range(0, 3));
                n_stall += k;
                for (int j = 0; j <= k; j++)
                    push(a == 0 ? K_WR : K_RD, s, a == 0 ? C_WR : C_RD, 1, 0, 0, j == k);
            end
        end
        push(K_DN, S - 1, C_DN, 1, 0, 0, 1'($urandom));
    endtask

    task automatic drive(input logic a);
        mem_ack = a;
        start   = 1'($urandom);
        mode    = 1'($urandom);
        abort   = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_run(input bit m, input bit ab);
        start = 1'b1; mode = m; abort = ab; mem_ack = 1'($urandom);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        nvec++;
        if (obs !== C_IDLE || slice_idx !== '0 || lane_idx !== '0 || prev_slice_idx !== SW'(S - 1)) begin
            miss++;
            $display("FAIL reset: ctl=%b s=%0d p=%0d l=%0d, want ctl=%b s=0 p=%0d l=0",
                     obs, slice_idx, prev_slice_idx, lane_idx, C_IDLE, S - 1);
        end
    endtask

    task automatic test_two_pass();
        int done_at = 0, nldx = 0, npar = 0, nmw = 0, nmr = 0;
        build(1'b0, 0);
        start_run(1'b0, 1'b0);
        foreach (tq[i]) begin
            nvec++;
            if (obs !== tq[i].ctl || (tq[i].chk_slice && {slice_idx, prev_slice_idx} !== {tq[i].slice, tq[i].prev})
                || (tq[i].chk_lane && lane_idx !== tq[i].lane)) begin
                miss++;
                $display("FAIL two_pass cyc %0d: ctl=%b s=%0d p=%0d l=%0d, want ctl=%b s=%0d p=%0d l=%0d",
                         i + 1, obs, slice_idx, prev_slice_idx, lane_idx, tq[i].ctl, tq[i].slice, tq[i].prev, tq[i].lane);
            end
            if (done) done_at = i + 1;
            nldx += int'(ld_x); npar += int'(parity_en); nmw += int'(mem_write); nmr += int'(mem_read);
            drive(tq[i].ack);
        end
        nvec++;
        if (done_at !== 1 + S * (2 * L + 4) + 1) begin
            miss++; $display("FAIL two_pass_latency: done at %0d, want %0d", done_at, 1 + S * (2 * L + 4) + 1);
        end
        nvec++;
        if (nldx !== 2 * S || npar !== 2 * L * S || nmw !== S || nmr !== S) begin
            miss++; $display("FAIL two_pass_counts: ldx=%0d par=%0d mw=%0d mr=%0d, want %0d %0d %0d %0d",
                             nldx, npar, nmw, nmr, 2 * S, 2 * L * S, S, S);
        end
        nvec++;
        if (obs !== C_IDLE) begin
            miss++; $display("FAIL two_pass_idle: ctl=%b, want %b", obs, C_IDLE);
        end
        start = 1'b0;
    endtask

    task automatic test_single_pass();
        int done_at = 0, nextra = 0;
        build(1'b1, 0);
        start_run(1'b1, 1'b0);
        foreach (tq[i]) begin
            nvec++;
            if (obs !== tq[i].ctl || (tq[i].chk_slice && {slice_idx, prev_slice_idx} !== {tq[i].slice, tq[i].prev})
                || (tq[i].chk_lane && lane_idx !== tq[i].lane)) begin
                miss++;
                $display("FAIL single_pass cyc %0d: ctl=%b s=%0d l=%0d, want ctl=%b s=%0d l=%0d",
                         i + 1, obs, slice_idx, lane_idx, tq[i].ctl, tq[i].slice, tq[i].lane);
            end
            if (done) done_at = i + 1;
            nextra += int'(ld_m) + int'(pre_in_sel);
            drive(tq[i].ack);
        end
        nvec++;
        if (done_at !== 1 + S * (L + 3) + 1 || nextra !== 0) begin
            miss++; $display("FAIL single_pass_latency: done at %0d ld_m/pre=%0d, want %0d and 0",
                             done_at, nextra, 1 + S * (L + 3) + 1);
        end
        nvec++;
        if (obs !== C_IDLE) begin
            miss++; $display("FAIL single_pass_idle: ctl=%b, want %b", obs, C_IDLE);
        end
        start = 1'b0;
    endtask

    task automatic test_stall();
        int done_at = 0;
        build(1'b0, 1);
        start_run(1'b0, 1'b0);
        foreach (tq[i]) begin
            nvec++;
            if (obs !== tq[i].ctl || (tq[i].chk_slice && {slice_idx, prev_slice_idx} !== {tq[i].slice, tq[i].prev})
                || (tq[i].chk_lane && lane_idx !== tq[i].lane)) begin
                miss++;
                $display("FAIL stall cyc %0d: ctl=%b s=%0d, want ctl=%b s=%0d", i + 1, obs, slice_idx, tq[i].ctl, tq[i].slice);
            end
            if (done) done_at = i + 1;
            drive(tq[i].ack);
        end
        nvec++;
        if (done_at !== 1 + S * (2 * L + 4) + 1 + 6 * S) begin
            miss++; $display("FAIL stall_latency: done at %0d, want %0d", done_at, 1 + S * (2 * L + 4) + 1 + 6 * S);
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    // Random mode and stalls; the first run also raises abort alongside start in IDLE
    task automatic test_random_runs();
        for (int r = 0; r < 6; r++) begin
            bit m;
            int done_at;
            m = 1'($urandom);
            done_at = 0;
            build(m, 2);
            start_run(m, r == 0);
            foreach (tq[i]) begin
                nvec++;
                if (obs !== tq[i].ctl || (tq[i].chk_slice && {slice_idx, prev_slice_idx} !== {tq[i].slice, tq[i].prev})
                    || (tq[i].chk_lane && lane_idx !== tq[i].lane)) begin
                    miss++;
                    $display("FAIL random_run %0d cyc %0d: ctl=%b s=%0d p=%0d l=%0d, want ctl=%b s=%0d p=%0d l=%0d",
                             r, i + 1, obs, slice_idx, prev_slice_idx, lane_idx, tq[i].ctl, tq[i].slice, tq[i].prev, tq[i].lane);
                end
                if (done) done_at = i + 1;
                drive(tq[i].ack);
            end
            nvec++;
            if (done_at !== 1 + S * (m ? L + 3 : 2 * L + 4) + 1 + n_stall) begin
                miss++; $display("FAIL random_latency %0d: done at %0d, want %0d",
                                 r, done_at, 1 + S * (m ? L + 3 : 2 * L + 4) + 1 + n_stall);
            end
            start = 1'b0;
            @(negedge clk);
        end
    endtask

    // First round aborts in PAR2 of slice 2; later rounds abort at a random cycle
    task automatic test_abort();
        for (int r = 0; r < 5; r++) begin
            int stop, ndone;
            bit m;
            m = (r == 0) ? 1'b0 : 1'($urandom);
            build(m, r == 0 ? 0 : 2);
            stop = int'($urandom_range(0, tq.size() - 1));
            if (r == 0)
                foreach (tq[i]) if (tq[i].kind == K_P2 && tq[i].sl == 2 && tq[i].lane == LW'(1)) stop = i;
            start_run(m, 1'b0);
            for (int i = 0; i <= stop; i++) begin
                nvec++;
                if (obs !== tq[i].ctl) begin
                    miss++; $display("FAIL abort_pre %0d cyc %0d: ctl=%b, want %b", r, i + 1, obs, tq[i].ctl);
                end
                mem_ack = (r == 0) ? 1'b1 : tq[i].ack;
                start = 1'($urandom);
                abort = (i == stop);
                @(negedge clk);
            end
            abort = 1'b0; start = 1'b0;
            nvec++;
            if (obs !== C_IDLE || slice_idx !== '0 || lane_idx !== '0 || prev_slice_idx !== SW'(S - 1)) begin
                miss++; $display("FAIL abort_idle %0d: ctl=%b s=%0d l=%0d, want ctl=%b s=0 l=0",
                                 r, obs, slice_idx, lane_idx, C_IDLE);
            end
            ndone = 0;
            repeat (3) begin
                mem_ack = 1'($urandom);
                @(negedge clk);
                ndone += int'(done) + int'(busy);
            end
            nvec++;
            if (ndone !== 0 || ready !== 1'b1) begin
                miss++; $display("FAIL abort_quiet %0d: done/busy cycles=%0d ready=%b, want 0 and 1", r, ndone, ready);
            end
        end
    endtask

    task automatic test_reset_midrun();
        int stop, ndone;
        build(1'b0, 2);
        stop = 0;
        foreach (tq[i]) if (stop == 0 && tq[i].kind == K_RD && tq[i].sl == 1) stop = i;
        start_run(1'b0, 1'b0);
        for (int i = 0; i <= stop; i++) begin
            nvec++;
            if (obs !== tq[i].ctl) begin
                miss++; $display("FAIL rst_pre cyc %0d: ctl=%b, want %b", i + 1, obs, tq[i].ctl);
            end
            mem_ack = tq[i].ack;
            start = 1'($urandom);
            rst = (i == stop);
            @(negedge clk);
        end
        rst = 1'b0; start = 1'b0;
        nvec++;
        if (obs !== C_IDLE || slice_idx !== '0 || lane_idx !== '0 || prev_slice_idx !== SW'(S - 1)) begin
            miss++; $display("FAIL rst_midrun: ctl=%b s=%0d p=%0d l=%0d, want ctl=%b s=0 p=%0d l=0",
                             obs, slice_idx, prev_slice_idx, lane_idx, C_IDLE, S - 1);
        end
        ndone = 0;
        repeat (3) begin
            mem_ack = 1'($urandom);
            @(negedge clk);
            ndone += int'(done) + int'(busy);
        end
        nvec++;
        if (ndone !== 0) begin
            miss++; $display("FAIL rst_quiet: done/busy cycles=%0d, want 0", ndone);
        end
    endtask

    initial begin
        test_reset();
        test_two_pass();
        test_single_pass();
        test_stall();
        test_random_runs();
        test_abort();
        test_reset_midrun();
        test_two_pass();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, miss);
        $finish;
    end

endmodule
